// File: rtl/subbytes_scheduler.sv
// subbytes_scheduler: shares one 32-bit S-box between the round SubBytes
// (four column passes) and key-expansion SubWord (single word).
// Ports: clk, reset_n (async, active low);
//   state_req/state_in/state_ready, state_out/state_done: 128-bit SubBytes op;
//   key_req/key_word/key_grant, key_result/key_valid: SubWord op;
//   sbox_in/sbox_out: external S-box; busy: column sequence running.
// Optional: define SUBBYTES_INTERLEAVE_EN to let SubWord preempt columns.
module subbytes_scheduler #(
  parameter int          NUM_COLS  = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         state_req,
  input  logic [127:0] state_in,
  output logic         state_ready,
  output logic [127:0] state_out,
  output logic         state_done,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_grant,
  output logic [31:0]  key_result,
  output logic         key_valid,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [1:0] LAST = 2'(NUM_COLS - 1);

  fsm_t         fsm;
  logic [1:0]   col;
  logic [127:0] src;
  logic [6:0]   sidx;
  logic         run;

  assign run = (fsm == RUN);

  // column 0 is the most significant word, so slice base is (3-col)*32
  assign sidx = {~col, 5'd0};

`ifdef SUBBYTES_INTERLEAVE_EN
  // set by a preemption, cleared by the following column:
  // key and columns alternate, neither starves
  logic flag;

  assign key_grant = key_req && (!run || !flag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag <= 1'b0;
    end else if (run) begin
      flag <= key_grant;
    end
  end
`else
  assign key_grant = key_req && !run;
`endif

  assign state_ready = !run && !key_req;
  assign busy        = run;

  always_comb begin
    sbox_in = IDLE_WORD;
    if (key_grant) begin
      sbox_in = key_word;
    end else if (run) begin
      sbox_in = src[sidx +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm        <= IDLE;
      col        <= 2'd0;
      src        <= '0;
      state_out  <= '0;
      key_result <= '0;
      state_done <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      state_done <= 1'b0;
      key_valid  <= key_grant;
      if (key_grant) begin
        key_result <= sbox_out;
      end
      unique case (1'b1)
        !run: begin
          if (state_req && state_ready) begin
            src <= state_in;
            col <= 2'd0;
            fsm <= RUN;
          end
        end
        run && !key_grant: begin
          state_out[sidx +: 32] <= sbox_out;
          col <= col + 2'd1;
          if (col == LAST) begin
            fsm        <= IDLE;
            state_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_scheduler.sv
// tb_subbytes_scheduler: queue-based transaction model of the scheduler
// checked every cycle, plus directed literal checks of latency and values.
module tb_subbytes_scheduler;

`ifdef SUBBYTES_INTERLEAVE_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         state_req = 1'b0;
  logic [127:0] state_in = '0;
  logic         state_ready;
  logic [127:0] state_out;
  logic         state_done;
  logic         key_req = 1'b0;
  logic [31:0]  key_word = '0;
  logic         key_grant;
  logic [31:0]  key_result;
  logic         key_valid;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         busy;

  logic [7:0] sb [256];

  subbytes_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .state_req(state_req), .state_in(state_in),
    .state_ready(state_ready), .state_out(state_out),
    .state_done(state_done),
    .key_req(key_req), .key_word(key_word),
    .key_grant(key_grant), .key_result(key_result),
    .key_valid(key_valid),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
  );

  assign sbox_out = {sb[sbox_in[31:24]], sb[sbox_in[23:16]],
                     sb[sbox_in[15:8]], sb[sbox_in[7:0]]};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r1, r2, r3, r4;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rl(inv); r2 = rl(r1); r3 = rl(r2); r4 = rl(r3);
      sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub32(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub128(logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = sub32(s[i*32 +: 32]);
    return r;
  endfunction

  // transaction model: queue of column words still to substitute
  logic [31:0]  mq [$];
  bit           m_flag, m_done, m_kv, mbusy, eg, er;
  logic [31:0]  m_kres, es;
  logic [127:0] m_sout, m_target;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      mq.delete();
      m_flag = 0; m_done = 0; m_kv = 0;
      m_kres = '0; m_sout = '0;
      chk("rst_state_out", state_out, 0);
      chk("rst_key_result", key_result, 0);
      chk("rst_done", state_done, 0);
      chk("rst_kvalid", key_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      mbusy = (mq.size() != 0);
      eg = key_req && (!mbusy || (IL && !m_flag));
      er = !mbusy && !key_req;
      es = eg ? key_word : (mbusy ? mq[0] : 32'h0);
      chk("m_busy", busy, mbusy);
      chk("m_grant", key_grant, eg);
      chk("m_ready", state_ready, er);
      chk("m_sbox_in", sbox_in, es);
      chk("m_done", state_done, m_done);
      chk("m_kvalid", key_valid, m_kv);
      chk("m_kresult", key_result, m_kres);
      if (!mbusy) chk("m_state_out", state_out, m_sout);
      m_kv = eg;
      if (eg) m_kres = sub32(key_word);
      m_done = 0;
      if (mbusy) begin
        if (eg) begin
          m_flag = 1;
        end else begin
          void'(mq.pop_front());
          m_flag = 0;
          if (mq.size() == 0) begin
            m_done = 1;
            m_sout = m_target;
          end
        end
      end else if (state_req && er) begin
        mq = {state_in[127:96], state_in[95:64],
              state_in[63:32], state_in[31:0]};
        m_target = sub128(state_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_state(input logic [127:0] v, output int c);
    state_req = 1'b1;
    state_in  = v;
    c = -1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (state_ready) begin
        c = cyc;
        tick();
        state_req = 1'b0;
        return;
      end
      tick();
    end
    state_req = 1'b0;
    chk("accept_timeout", 1, 0);
  endtask

  task automatic wait_done(output int d, output int nb);
    d = -1;
    nb = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (state_done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) chk("done_timeout", 1, 0);
    tick();
  endtask

  localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] T1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  int c, d, nb, g, cnt;
  logic [15:0] mask;
  logic [127:0] v;
  bit gk;

  initial begin
    build_sbox();
    chk("pin_sb00", sb[0], 8'h63);
    chk("pin_sub32", sub32(32'hcf4f3c09), 32'h8a84eb01);
    chk("pin_sub128", sub128(T1_IN), T1_OUT);

    tick();
    tick();
    chk("rst_ready", state_ready, 1);
    chk("rst_grant", key_grant, 0);
    chk("rst_sbox_in", sbox_in, 0);
    reset_n = 1'b1;
    tick();

    // plain state op
    start_state(T1_IN, c);
    wait_done(d, nb);
    chk("t1_latency", d - c, 5);
    chk("t1_busy_cycles", nb, 4);
    chk("t1_state_out", state_out, T1_OUT);

    // SubWord in idle
    key_req  = 1'b1;
    key_word = 32'hcf4f3c09;
    #1;
    chk("t2_grant", key_grant, 1);
    chk("t2_sbox_in", sbox_in, 32'hcf4f3c09);
    tick();
    key_req = 1'b0;
    chk("t2_kvalid", key_valid, 1);
    chk("t2_kresult", key_result, 32'h8a84eb01);
    tick();

    // simultaneous requests
    key_req   = 1'b1;
    key_word  = $urandom;
    state_req = 1'b1;
    state_in  = '0;
    #1;
    chk("t3_grant", key_grant, 1);
    chk("t3_ready0", state_ready, 0);
    c = cyc;
    tick();
    key_req = 1'b0;
    #1;
    chk("t3_ready1", state_ready, 1);
    tick();
    state_req = 1'b0;
    wait_done(d, nb);
    chk("t3_latency", d - c, 6);
    chk("t3_state_out", state_out, {16{8'h63}});

    // key pulse during column 1
    v = {$urandom, $urandom, $urandom, $urandom};
    start_state(v, c);
    tick();
    key_req  = 1'b1;
    key_word = $urandom;
    g = -1;
    d = -1;
    for (int n = 0; n < 12 && d < 0; n++) begin
      @(negedge clk);
      if (key_grant && g < 0) g = cyc;
      if (state_done) d = cyc;
      tick();
      if (g >= 0) key_req = 1'b0;
    end
    key_req = 1'b0;
    chk("t4_grant_cyc", g - c, IL ? 2 : 5);
    chk("t4_done_cyc", d - c, IL ? 6 : 5);
    chk("t4_state_out", state_out, sub128(v));
    tick();

    // key held six cycles during RUN
    v = {$urandom, $urandom, $urandom, $urandom};
    start_state(v, c);
    key_req  = 1'b1;
    key_word = $urandom;
    mask = '0;
    d = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (key_grant) mask[cyc - c] = 1'b1;
      if (state_done) d = cyc;
      tick();
      if (cyc - c >= 7) key_req = 1'b0;
    end
    chk("t5_grant_mask", mask, IL ? 16'h002a : 16'h0060);
    chk("t5_done_cyc", d - c, IL ? 8 : 5);
    chk("t5_state_out", state_out, sub128(v));

    // reset during column 2
    v = {$urandom, $urandom, $urandom, $urandom};
    start_state(v, c);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_state_out", state_out, 0);
    chk("t6_key_result", key_result, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", state_done, 0);
    chk("t6_kvalid", key_valid, 0);
    chk("t6_sbox_in", sbox_in, 0);
    tick();
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (state_done) cnt++;
      tick();
    end
    chk("t6_no_done", cnt, 0);
    start_state(T1_IN, c);
    wait_done(d, nb);
    chk("t6_latency", d - c, 5);
    chk("t6_state_out2", state_out, T1_OUT);

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      gk = key_grant;
      tick();
      if (!key_req || gk) begin
        key_req  = ($urandom_range(0, 3) == 0);
        key_word = $urandom;
      end
      state_req = ($urandom_range(0, 2) == 0);
      state_in  = {$urandom, $urandom, $urandom, $urandom};
    end
    key_req   = 1'b0;
    state_req = 1'b0;
    for (int n = 0; n < 12; n++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
